// File: rtl/axis_vip_pkg.sv
// axis_vip_pkg: shared types and constants for the image VIP stream blocks
package axis_vip_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} frame_src_state_t;

    localparam logic PAT_SEQ      = 1'b0;
    localparam logic PAT_COORD    = 1'b1;
    localparam int   SOURCE_BYTES = 4;

endpackage

// File: rtl/axis_frame_cnt.sv
// axis_frame_cnt: column/row/sequence counters with line and frame terminal flags
module axis_frame_cnt #(
    parameter int WIDTH    = 16,
    parameter int HEIGHT   = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr,
    input  logic                adv,
    output logic [CNT_BITS-1:0] col_nxt,
    output logic [CNT_BITS-1:0] row_nxt,
    output logic [CNT_BITS-1:0] seq_nxt,
    output logic                line_end,
    output logic                frame_end
);

    logic [CNT_BITS-1:0] col, row, seq;

    // The *_nxt values are the coordinates of the beat that follows the current one
    always_comb begin
        line_end  = col == CNT_BITS'(WIDTH - 1);
        frame_end = line_end && row == CNT_BITS'(HEIGHT - 1);
        col_nxt   = line_end ? '0 : col + 1'b1;
        row_nxt   = line_end ? row + 1'b1 : row;
        seq_nxt   = seq + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
            seq <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
            seq <= '0;
        end else if (adv) begin
            col <= col_nxt;
            row <= row_nxt;
            seq <= seq_nxt;
        end
    end

endmodule

// File: rtl/axis_frame_src.sv
// axis_frame_src: AXI-Stream master emitting synthetic WIDTH x HEIGHT frames
// with line gaps, TLAST per line and a frame_done pulse.
module axis_frame_src
    import axis_vip_pkg::*;
#(
    parameter int OUTPUT_BYTES = SOURCE_BYTES,
    parameter int OUTPUT_BITS  = OUTPUT_BYTES * 8,
    parameter int WIDTH        = 16,
    parameter int HEIGHT       = 8,
    parameter int LINE_GAP     = 0,
    parameter int CNT_BITS     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   pattern_sel_i,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [OUTPUT_BITS-1:0] axis_m_data_o,
    output logic                   axis_m_valid_o,
    input  logic                   axis_m_ready_i,
    output logic                   axis_m_last_o
);

    frame_src_state_t     state;
    logic                 pat;
    logic [CNT_BITS-1:0]  gap_cnt;
    logic [CNT_BITS-1:0]  col_nxt, row_nxt, seq_nxt;
    logic                 line_end, frame_end;
    logic                 hs, clr, adv;
    logic [OUTPUT_BITS-1:0] data_nxt;

    always_comb begin
        hs       = axis_m_valid_o && axis_m_ready_i;
        clr      = state == IDLE && start_i;
        adv      = state == SEND && hs;
        data_nxt = pat == PAT_COORD ? OUTPUT_BITS'({row_nxt, col_nxt}) : OUTPUT_BITS'(seq_nxt);
    end

    axis_frame_cnt #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .CNT_BITS (CNT_BITS)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr       (clr),
        .adv       (adv),
        .col_nxt   (col_nxt),
        .row_nxt   (row_nxt),
        .seq_nxt   (seq_nxt),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // Next beat's data/last are loaded on the handshake edge so outputs stay registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            pat            <= PAT_SEQ;
            gap_cnt        <= '0;
            busy_o         <= 1'b0;
            frame_done_o   <= 1'b0;
            axis_m_data_o  <= '0;
            axis_m_valid_o <= 1'b0;
            axis_m_last_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    pat            <= pattern_sel_i ? PAT_COORD : PAT_SEQ;
                    state          <= SEND;
                    busy_o         <= 1'b1;
                    axis_m_valid_o <= 1'b1;
                    axis_m_data_o  <= '0;
                    axis_m_last_o  <= WIDTH == 1;
                end
                SEND: if (hs) begin
                    if (frame_end) begin
                        state          <= DONE;
                        axis_m_valid_o <= 1'b0;
                        axis_m_last_o  <= 1'b0;
                        frame_done_o   <= 1'b1;
                    end else begin
                        axis_m_data_o <= data_nxt;
                        axis_m_last_o <= col_nxt == CNT_BITS'(WIDTH - 1);
                        if (line_end && LINE_GAP > 0) begin
                            state          <= GAP;
                            axis_m_valid_o <= 1'b0;
                            gap_cnt        <= '0;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == CNT_BITS'(LINE_GAP - 1)) begin
                        state          <= SEND;
                        axis_m_valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    busy_o       <= 1'b0;
                    frame_done_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_src.sv
// tb_axis_frame_src: three source configurations checked every cycle against
// a frame-level queue model, plus literal expectations on captured beats.
module tb_axis_frame_src;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [3];
    logic        sel   [3];
    logic        ready [3];
    logic        valid [3];
    logic        last  [3];
    logic        busy  [3];
    logic        done  [3];
    logic [31:0] data  [3];

    int    n_vec = 0;
    int    n_bad = 0;
    beat_t r0[$];
    beat_t r2[$];

    always #5 clk = ~clk;

    function automatic int pw(input int k);
        return k == 2 ? 1 : 4;
    endfunction
    function automatic int ph(input int k);
        return k == 2 ? 1 : 2;
    endfunction
    function automatic int pg(input int k);
        return k == 1 ? 3 : 0;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, k, $time, a, e);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int W = pw(k);
        localparam int H = ph(k);
        localparam int G = pg(k);

        axis_frame_src #(
            .OUTPUT_BYTES (4),
            .WIDTH        (W),
            .HEIGHT       (H),
            .LINE_GAP     (G),
            .CNT_BITS     (16)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .start_i        (start[k]),
            .pattern_sel_i  (sel[k]),
            .busy_o         (busy[k]),
            .frame_done_o   (done[k]),
            .axis_m_data_o  (data[k]),
            .axis_m_valid_o (valid[k]),
            .axis_m_ready_i (ready[k]),
            .axis_m_last_o  (last[k])
        );

        // Model: queue of beats still owed in the current frame, gap cycles still owed,
        // and the expected busy/done levels for the present cycle.
        beat_t q[$];
        int    gap_left = 0;
        bit    eb = 0;
        bit    ed = 0;

        always @(negedge clk) begin
            beat_t b;
            bit ev, acc;
            if (rst) begin
                q.delete();
                gap_left = 0;
                eb = 0;
                ed = 0;
            end else begin
                ev = q.size() > 0 && gap_left == 0;
                chk("busy", k, 32'(busy[k]), 32'(eb));
                chk("frame_done", k, 32'(done[k]), 32'(ed));
                chk("valid", k, 32'(valid[k]), 32'(ev));
                if (ev) begin
                    chk("data", k, data[k], q[0].d);
                    chk("last", k, 32'(last[k]), 32'(q[0].l));
                end
                acc = start[k] && !eb;
                if (ed) eb = 0;
                ed = 0;
                if (gap_left > 0) gap_left--;
                else if (ev && ready[k]) begin
                    b = q.pop_front();
                    if (q.size() == 0) ed = 1;
                    else if (b.l) gap_left = G;
                end
                if (acc) begin
                    eb = 1;
                    for (int r = 0; r < H; r++)
                        for (int c = 0; c < W; c++)
                            q.push_back(beat_t'{sel[k] ? {16'(r), 16'(c)} : 32'(r * W + c), c == W - 1});
                end
            end
        end
    end

    task automatic run_frame(input logic s, input int mode);
        int n = 0;
        bit pat6[6] = '{1, 0, 0, 1, 0, 1};
        r0.delete();
        r2.delete();
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b1;
            sel[k]   = s;
            ready[k] = mode == 2 ? 1'($urandom % 2) : 1'b1;
        end
        do begin
            @(negedge clk);
            if (valid[0] && ready[0]) r0.push_back(beat_t'{data[0], last[0]});
            if (valid[2] && ready[2]) r2.push_back(beat_t'{data[2], last[2]});
            @(posedge clk); #2;
            n++;
            for (int k = 0; k < 3; k++) begin
                start[k] = (mode == 2 && n < 40) ? 1'($urandom % 8 == 0) : 1'b0;
                sel[k]   = 1'($urandom % 2);
                ready[k] = mode == 0 ? 1'b1 : mode == 1 ? pat6[n % 6] : 1'($urandom % 2);
            end
        end while ((busy[0] || busy[1] || busy[2] || n < 45) && n < 600);
        chk("frame_timeout", 0, 32'(n < 600), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            sel[k]   = 1'b0;
            ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 32'(valid[k]), 32'd0);
            chk("rst_last", k, 32'(last[k]), 32'd0);
            chk("rst_data", k, data[k], 32'd0);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
            chk("rst_done", k, 32'(done[k]), 32'd0);
        end
        @(posedge clk); #2;
        rst = 1'b0;

        run_frame(1'b0, 0);
        chk("seq_count", 0, 32'(r0.size()), 32'd8);
        for (int i = 0; i < 8 && i < r0.size(); i++) begin
            chk("seq_data", 0, r0[i].d, 32'(i));
            chk("seq_last", 0, 32'(r0[i].l), 32'(i == 3 || i == 7));
        end
        chk("w1_count", 2, 32'(r2.size()), 32'd1);
        if (r2.size() > 0) chk("w1_last", 2, 32'(r2[0].l), 32'd1);

        run_frame(1'b1, 0);
        chk("coord_count", 0, 32'(r0.size()), 32'd8);
        if (r0.size() == 8) begin
            chk("coord_b1", 0, r0[1].d, 32'h0000_0001);
            chk("coord_b3", 0, r0[3].d, 32'h0000_0003);
            chk("coord_b4", 0, r0[4].d, 32'h0001_0000);
            chk("coord_b7", 0, r0[7].d, 32'h0001_0003);
        end

        run_frame(1'b0, 1);
        chk("stall_count", 0, 32'(r0.size()), 32'd8);
        for (int i = 0; i < 8 && i < r0.size(); i++)
            chk("stall_data", 0, r0[i].d, 32'(i));

        repeat (6) run_frame(1'($urandom % 2), 2);

        // Ignored second start, then asynchronous abort after beat 2
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b1;
            sel[k]   = 1'b0;
            ready[k] = 1'b1;
        end
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) start[k] = 1'b1;
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        @(posedge clk); #3;
        chk("pre_abort_valid", 0, 32'(valid[0]), 32'd1);
        chk("pre_abort_data", 0, data[0], 32'd3);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort_valid", k, 32'(valid[k]), 32'd0);
            chk("abort_busy", k, 32'(busy[k]), 32'd0);
            chk("abort_done", k, 32'(done[k]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        run_frame(1'b0, 0);
        chk("restart_count", 0, 32'(r0.size()), 32'd8);
        if (r0.size() > 0) chk("restart_first", 0, r0[0].d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
